// File: rtl/gram_pkg.sv
// Shared GRAM geometry and arbiter state encoding for the text-mode display.
// Both the arbiter and the VGA scanout import these constants.
package gram_pkg;

  localparam int unsigned SCREEN_COLS = 80;
  localparam int unsigned SCREEN_ROWS = 30;
  localparam int unsigned ADDR_WIDTH  = 12;
  localparam int unsigned DATA_WIDTH  = 7;
  localparam int unsigned CELL_COUNT  = SCREEN_COLS * SCREEN_ROWS;

  localparam logic [DATA_WIDTH-1:0] FILL_CHAR = 7'h20;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StClear
  } gram_state_e;

endpackage

// File: rtl/gram_write_fifo.sv
// Synchronous FIFO holding queued host character writes as {address, data}.
// Depth must be a power of two so the pointers wrap naturally.
module gram_write_fifo #(
  parameter int unsigned Width = 19,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntWidth'(do_push) - CntWidth'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gram_arbiter.sv
// Single-port GRAM arbiter: scanout owns the RAM in the visible area; queued host
// writes and full-screen clears are issued only during blanking.
module gram_arbiter
  import gram_pkg::*;
#(
  parameter int unsigned          AddrWidth = ADDR_WIDTH,
  parameter int unsigned          DataWidth = DATA_WIDTH,
  parameter int unsigned          CellCount = CELL_COUNT,
  parameter int unsigned          FifoDepth = 4,
  parameter logic [DataWidth-1:0] FillChar  = FILL_CHAR
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [AddrWidth-1:0] wr_address_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 clear_req_i,
  output logic                 busy_o,
  input  logic                 video_active_i,
  input  logic [AddrWidth-1:0] scan_address_i,
  output logic [AddrWidth-1:0] gram_address_o,
  output logic [DataWidth-1:0] gram_data_o,
  output logic                 gram_we_o
);

  localparam int unsigned CntWidth = $clog2(FifoDepth) + 1;
  localparam logic [AddrWidth-1:0] LastCell = AddrWidth'(CellCount - 1);

  gram_state_e          state_q, state_d;
  logic                 clear_pending_q, clear_pending_d;
  logic [AddrWidth-1:0] clear_addr_q, clear_addr_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AddrWidth-1:0] head_addr;
  logic [DataWidth-1:0] head_data;
  logic [CntWidth-1:0]  fifo_count;
  logic [CntWidth-1:0]  fifo_count_next;
  logic                 queue_nonempty_d;

  gram_write_fifo #(
    .Width (AddrWidth + DataWidth),
    .Depth (FifoDepth)
  ) u_write_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i ({wr_address_i, wr_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o ({head_addr, head_data}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign wr_ready_o = !fifo_full && !clear_pending_q && (state_q != StClear);
  assign fifo_push  = wr_valid_i && wr_ready_o;
  assign busy_o     = clear_pending_q || (state_q == StClear) || !fifo_empty;

  assign fifo_count_next  = fifo_count + CntWidth'(fifo_push) - CntWidth'(fifo_pop);
  assign queue_nonempty_d = (fifo_count_next != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      clear_pending_q <= 1'b0;
      clear_addr_q    <= '0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      clear_addr_q    <= clear_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    clear_addr_d    = clear_addr_q;
    case (state_q)
      StClear: begin
        // The sweep only advances in blanking; clear_req is ignored here.
        if (!video_active_i) begin
          if (clear_addr_q == LastCell) begin
            clear_addr_d = '0;
            state_d      = queue_nonempty_d ? StDrain : StIdle;
          end else begin
            clear_addr_d = clear_addr_q + AddrWidth'(1);
          end
        end
      end
      StIdle, StDrain: begin
        if (clear_pending_q && fifo_empty) begin
          state_d         = StClear;
          clear_addr_d    = '0;
          clear_pending_d = 1'b0;
        end else begin
          if (clear_req_i) clear_pending_d = 1'b1;
          state_d = queue_nonempty_d ? StDrain : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gram_address_o = scan_address_i;
    gram_data_o    = head_data;
    gram_we_o      = 1'b0;
    fifo_pop       = 1'b0;
    if (!video_active_i) begin
      if (state_q == StClear) begin
        gram_address_o = clear_addr_q;
        gram_data_o    = FillChar;
        gram_we_o      = 1'b1;
      end else if (!fifo_empty) begin
        // Out-of-range entries still pop, but never reach the RAM.
        gram_address_o = head_addr;
        gram_data_o    = head_data;
        gram_we_o      = (head_addr <= LastCell);
        fifo_pop       = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gram_arbiter.sv
// Scenario bench for gram_arbiter with a queue-based reference model for the
// randomized traffic phase.
module tb_gram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [11:0] wr_address = '0;
  logic [6:0]  wr_data = '0;
  logic        clear_req = 1'b0;
  logic        busy;
  logic        video_active = 1'b0;
  logic [11:0] scan_address = '0;
  logic [11:0] gram_address;
  logic [6:0]  gram_data;
  logic        gram_we;

  int checks = 0;
  int errors = 0;
  int vis_viol = 0;
  logic [18:0] wlog[$];

  typedef struct {
    logic [11:0] a;
    logic [6:0]  d;
  } ent_t;

  gram_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_address_i   (wr_address),
    .wr_data_i      (wr_data),
    .clear_req_i    (clear_req),
    .busy_o         (busy),
    .video_active_i (video_active),
    .scan_address_i (scan_address),
    .gram_address_o (gram_address),
    .gram_data_o    (gram_data),
    .gram_we_o      (gram_we)
  );

  always #5 clk = ~clk;

  // Log every GRAM write and any access that violates scanout ownership.
  always @(negedge clk) begin
    if (!rst) begin
      if (gram_we === 1'b1) wlog.push_back({gram_address, gram_data});
      if (video_active && (gram_we !== 1'b0 || gram_address !== scan_address)) vis_viol++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (gram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", gram_we); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", wr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_rst ready/busy got %b/%b exp 1/0", wr_ready, busy);
    end
  endtask

  task automatic test_single_write();
    video_active = 1'b0;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_address = 12'd5; wr_data = 7'h41;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", wr_ready); end
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk);
    checks++; if (gram_we !== 1'b1 || gram_address !== 12'd5 || gram_data !== 7'h41) begin
      errors++;
      $display("FAIL single_write got we=%b a=%0d d=%h exp we=1 a=5 d=41", gram_we, gram_address,
               gram_data);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || gram_we !== 1'b0) begin
      errors++; $display("FAIL single_done busy/we got %b/%b exp 0/0", busy, gram_we);
    end
  endtask

  task automatic test_held_visible();
    logic [11:0] ea[4];
    logic [6:0]  ed[4];
    for (int i = 0; i < 4; i++) begin
      ea[i] = 12'($urandom_range(0, 2399));
      ed[i] = 7'($urandom);
    end
    vis_viol = 0;
    video_active = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      scan_address = 12'($urandom_range(0, 2399));
      wr_valid = (c < 5);
      if (c < 4) begin
        wr_address = ea[c]; wr_data = ed[c];
      end else if (c == 4) begin
        wr_address = 12'd7; wr_data = 7'h7f;
        @(negedge clk);
        checks++; if (wr_ready !== 1'b0) begin
          errors++; $display("FAIL held_full_ready got %b exp 0", wr_ready);
        end
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    video_active = 1'b0;
    checks++; if (vis_viol != 0) begin
      errors++; $display("FAIL held_visible violations got %0d exp 0", vis_viol);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (gram_we !== 1'b1 || gram_address !== ea[i] || gram_data !== ed[i]) begin
        errors++;
        $display("FAIL held_order[%0d] got we=%b a=%0d d=%h exp we=1 a=%0d d=%h", i, gram_we,
                 gram_address, gram_data, ea[i], ed[i]);
      end
    end
    @(negedge clk);
    checks++; if (gram_we !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL held_after we/busy got %b/%b exp 0/0", gram_we, busy);
    end
  endtask

  task automatic test_out_of_range();
    logic [6:0] d0, d1;
    d0 = 7'($urandom);
    d1 = 7'($urandom);
    video_active = 1'b0;
    @(posedge clk); #1;
    wlog.delete();
    wr_valid = 1'b1; wr_address = 12'd2400; wr_data = d0;
    @(posedge clk); #1;
    wr_address = 12'd2399; wr_data = d1;
    @(negedge clk);
    checks++; if (gram_we !== 1'b0) begin errors++; $display("FAIL oor_drop_we got %b exp 0", gram_we); end
    @(posedge clk); #1 wr_valid = 1'b0;
    repeat (4) @(posedge clk);
    checks++; if (wlog.size() != 1) begin
      errors++; $display("FAIL oor_count got %0d exp 1", wlog.size());
    end else begin
      checks++; if (wlog[0] !== {12'd2399, d1}) begin
        errors++; $display("FAIL oor_entry got %h exp %h", wlog[0], {12'd2399, d1});
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oor_busy got %b exp 0", busy); end
  endtask

  task automatic test_random_traffic();
    ent_t mq[$];
    ent_t e;
    logic exp_ready, exp_we;
    logic [11:0] exp_addr;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      video_active = ($urandom_range(0, 1) == 1);
      scan_address = 12'($urandom_range(0, 2399));
      wr_valid = ($urandom_range(0, 9) < 6);
      wr_address = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(2400, 4095))
                                                : 12'($urandom_range(0, 2399));
      wr_data = 7'($urandom);
      @(negedge clk);
      exp_ready = (mq.size() < 4);
      exp_we = 1'b0;
      exp_addr = scan_address;
      if (!video_active && mq.size() > 0) begin
        exp_addr = mq[0].a;
        exp_we = (mq[0].a < 12'd2400);
      end
      checks++; if (wr_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, wr_ready, exp_ready);
      end
      checks++; if (gram_we !== exp_we || gram_address !== exp_addr) begin
        errors++;
        $display("FAIL rnd_port c=%0d got we=%b a=%0d exp we=%b a=%0d", c, gram_we, gram_address,
                 exp_we, exp_addr);
      end
      if (exp_we) begin
        checks++; if (gram_data !== mq[0].d) begin
          errors++; $display("FAIL rnd_data c=%0d got %h exp %h", c, gram_data, mq[0].d);
        end
      end
      checks++; if (busy !== (mq.size() > 0)) begin
        errors++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy, mq.size() > 0);
      end
      if (!video_active && mq.size() > 0) void'(mq.pop_front());
      if (wr_valid && exp_ready) begin
        e.a = wr_address; e.d = wr_data;
        mq.push_back(e);
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; video_active = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_drain_busy got %b exp 0", busy); end
  endtask

  task automatic test_clear_with_queued();
    logic [11:0] ea0, ea1;
    logic [6:0]  ed0, ed1;
    logic [18:0] expv;
    int cyc, ready_bad, seq_bad, first_bad;
    bit second, done;
    ea0 = 12'($urandom_range(0, 2399)); ed0 = 7'($urandom);
    ea1 = 12'($urandom_range(0, 2399)); ed1 = 7'($urandom);
    @(posedge clk); #1;
    wlog.delete(); vis_viol = 0;
    video_active = 1'b1;
    wr_valid = 1'b1; wr_address = ea0; wr_data = ed0;
    @(posedge clk); #1;
    wr_address = ea1; wr_data = ed1;
    @(posedge clk); #1;
    wr_valid = 1'b0; clear_req = 1'b1;
    cyc = 0; ready_bad = 0; second = 1'b0; done = 1'b0;
    while (cyc < 12000 && !done) begin
      @(posedge clk); #1;
      clear_req = 1'b0;
      if (!second && wlog.size() >= 1200) begin
        clear_req = 1'b1; second = 1'b1;
      end
      video_active = ($urandom_range(0, 3) == 0);
      scan_address = 12'($urandom_range(0, 2399));
      wr_valid = (wlog.size() < 2000) && ($urandom_range(0, 1) == 1);
      wr_address = 12'd100; wr_data = 7'h55;
      @(negedge clk);
      if (busy && wr_ready) ready_bad++;
      if (!busy) done = 1'b1;
      cyc++;
    end
    wr_valid = 1'b0; clear_req = 1'b0; video_active = 1'b0;
    repeat (20) @(posedge clk);
    checks++; if (!done) begin errors++; $display("FAIL clear_timeout got busy=%b exp 0", busy); end
    checks++; if (ready_bad != 0) begin
      errors++; $display("FAIL clear_ready cycles got %0d exp 0", ready_bad);
    end
    checks++; if (vis_viol != 0) begin
      errors++; $display("FAIL clear_visible violations got %0d exp 0", vis_viol);
    end
    checks++; if (wlog.size() != 2402) begin
      errors++; $display("FAIL clear_count got %0d exp 2402", wlog.size());
    end
    seq_bad = 0; first_bad = -1;
    for (int i = 0; i < wlog.size() && i < 2402; i++) begin
      if (i == 0) expv = {ea0, ed0};
      else if (i == 1) expv = {ea1, ed1};
      else expv = {12'(i - 2), 7'h20};
      if (wlog[i] !== expv) begin
        seq_bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++; if (seq_bad != 0) begin
      errors++; $display("FAIL clear_sequence bad entries got %0d exp 0 (first at %0d)", seq_bad,
                         first_bad);
    end
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clear_end_ready got %b exp 1", wr_ready); end
  endtask

  task automatic test_reset_mid_clear();
    bit found;
    video_active = 1'b0;
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      @(negedge clk);
      if (gram_we === 1'b1 && gram_address === 12'd1000) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midclr_reach got 0 exp 1"); end
    #1 rst = 1'b1;
    #1;
    checks++; if (gram_we !== 1'b0) begin errors++; $display("FAIL midclr_async_we got %b exp 0", gram_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midclr_async_busy got %b exp 0", busy); end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    wlog.delete();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL midclr_release busy/ready got %b/%b exp 0/1", busy, wr_ready);
    end
    repeat (50) @(posedge clk);
    checks++; if (wlog.size() != 0) begin
      errors++; $display("FAIL midclr_resumed writes got %0d exp 0", wlog.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_held_visible();
    test_out_of_range();
    test_random_traffic();
    test_clear_with_queued();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gram_arbiter.md
# gram_arbiter

Owns the single-port character RAM (GRAM) that holds the 80x30 text screen. The VGA scanout has absolute priority whenever it is in the visible area. This block queues host character writes and issues them to GRAM only during blanking, and sequences a full-screen clear. It sits between the host-side command path (UART/CPU) and GRAM, alongside the VGA timing/scanout block.

## Interface
- `ADDR_WIDTH`, 12, GRAM address width
- `DATA_WIDTH`, 7, character code width (ASCII)
- `CELL_COUNT`, 2400, number of valid cells (80 columns x 30 rows)
- `FIFO_DEPTH`, 4, host write queue depth (power of 2)
- `FILL_CHAR`, 7'h20, code written by clear (space)

- `clk`  in  1  pixel clock, the same clock as the VGA scanout
- `rst`  in  1  asynchronous, active-high reset
- `wr_valid`  in  1  host write request
- `wr_ready`  out  1  host write accepted when `wr_valid && wr_ready` at posedge
- `wr_address`  in  ADDR_WIDTH  target cell
- `wr_data`  in  DATA_WIDTH  character code
- `clear_req`  in  1  single-cycle pulse that requests a screen clear
- `busy`  out  1  clear pending, clearing, or queue non-empty
- `video_active`  in  1  high while scanout is in the visible area and owns GRAM
- `scan_address`  in  ADDR_WIDTH  scanout read address
- `gram_address`  out  ADDR_WIDTH  to GRAM
- `gram_data`  out  DATA_WIDTH  to GRAM write data
- `gram_we`  out  1  GRAM write enable

## Operation
- **Queue.** Synchronous FIFO of {address, data}, depth FIFO_DEPTH.
  - `wr_ready` = !full && !clear_pending && state != CLEAR.
  - `wr_ready` is derived from the registered count. A pop in the same cycle does not raise ready while full.
- **FSM states:**
  - IDLE: queue empty, no clear pending.
  - DRAIN: queue non-empty.
  - CLEAR: sweeping.
- **Clear sequencing.**
  - A `clear_req` pulse sets `clear_pending`. Writes already queued drain first.
  - When `clear_pending` is set and the queue is empty: go to CLEAR, reset `clear_addr` to 0, and clear `clear_pending`.
  - `clear_req` is ignored while `clear_pending` is set or the state is CLEAR.
- **Port mux (combinational):**
  - `video_active`=1: `gram_address`=`scan_address`, `gram_we`=0, nothing advances.
  - `video_active`=0 and state CLEAR: address=`clear_addr`, data=FILL_CHAR, we=1. `clear_addr` increments. After writing CELL_COUNT-1, go to IDLE (or DRAIN if non-empty; the queue is empty by construction).
  - `video_active`=0 and queue non-empty: address/data come from the FIFO head and the entry pops. `gram_we`=1 only if head address < CELL_COUNT. Out-of-range entries are popped and silently dropped.
  - Otherwise: `gram_address`=`scan_address`, `gram_we`=0.
- **Ordering.** Writes reach GRAM in acceptance order. A clear is applied after all writes accepted before the request.
- **Reset** (asynchronous, any time including mid-clear): queue empty, `clear_pending`=0, state IDLE, `clear_addr`=0. Outputs read `wr_ready`=1, `busy`=0, `gram_we`=0. An interrupted clear is abandoned, not resumed.

## Timing
- A write accepted at edge N is issued to GRAM in cycle N+1 at the earliest, if `video_active`=0 then. Otherwise it is issued in the first blanking cycle after N.
- One GRAM write per blanking cycle, maximum.
- A clear occupies exactly CELL_COUNT blanking cycles: 2400 cycles, roughly 15 lines at 160 blanking clocks per line.
- `busy` falls in the cycle after the last GRAM write of the final pending operation.
- `gram_we` and `gram_address` are combinational from state and `video_active`. GRAM samples them at the next posedge.

## Structure
- Shared package `gram_pkg`:
  - ADDR_WIDTH, DATA_WIDTH, CELL_COUNT (as 80*30), FILL_CHAR.
  - State enum {IDLE, DRAIN, CLEAR}.
  - The VGA scanout imports the same geometry constants.
- One sub-module, `gram_write_fifo`: synchronous FIFO with push/pop, full/empty, and the count kept as a register.

## Test plan
- **Single write:**
  - Stimulus: reset, then `video_active`=0. Write addr 5, data 7'h41.
  - Required: `gram_we`=1 with 5/0x41 exactly one cycle after acceptance. `busy` returns to 0 the next cycle.
- **Held during visible area:**
  - Stimulus: `video_active`=1 for 100 cycles. Push 4 writes.
  - Required: `wr_ready`=0 after the 4th. No `gram_we`, and `gram_address` tracks `scan_address`.
  - Then drop `video_active`: 4 consecutive writes, in order.
- **Clear with queued writes:**
  - Stimulus: 2 writes queued, then `clear_req`.
  - Required: the 2 writes issue first. Then 2400 `gram_we` cycles with addresses 0..2399, data 0x20.
  - `wr_ready`=0 throughout. A second `clear_req` mid-sweep changes nothing.
- **Out-of-range drop:**
  - Stimulus: write addr 2400, then addr 2399.
  - Required: only 2399 is written. Queue empty afterwards.
- **Reset mid-clear:**
  - Stimulus: assert `rst` at sweep address 1000.
  - Required: `gram_we`=0 immediately (asynchronous). After release, state IDLE, `busy`=0, `wr_ready`=1, and no further clear writes.
